// File: rtl/wave_rom_sequencer_if.sv
// rtl/wave_rom_sequencer_if.sv - control, waveform ROM and DAC signal bundle for wave_rom_sequencer
interface wave_rom_sequencer_if #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8
);
    logic [PHASE_WIDTH-1:0] cfg_fword;
    logic [7:0]             cfg_amp;
    logic [15:0]            cfg_burst;
    logic                   cfg_load;
    logic                   start;
    logic                   stop;
    logic [ADDR_WIDTH-1:0]  rom_addr;
    logic [DATA_WIDTH-1:0]  rom_data;
    logic [DATA_WIDTH-1:0]  dac_data;
    logic                   dac_valid;
    logic                   busy;
    logic                   done;

    // master is the control/ROM side; slave is the sequencer
    modport master (
        output cfg_fword, cfg_amp, cfg_burst, cfg_load, start, stop, rom_data,
        input  rom_addr, dac_data, dac_valid, busy, done
    );

    modport slave (
        input  cfg_fword, cfg_amp, cfg_burst, cfg_load, start, stop, rom_data,
        output rom_addr, dac_data, dac_valid, busy, done
    );
endinterface

// File: rtl/wave_rom_sequencer.sv
// rtl/wave_rom_sequencer.sv - phase-accumulator waveform ROM sequencer with burst mode and amplitude scaling
module wave_rom_sequencer #(
    parameter int                    PHASE_WIDTH = 32,
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_CODE   = 8'h80
) (
    input  logic                clk,
    input  logic                rst_n,
    wave_rom_sequencer_if.slave bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int                  PROD_WIDTH = DATA_WIDTH + 10;
    localparam logic [DATA_WIDTH:0] MIDSCALE   = (DATA_WIDTH + 1)'(1) << (DATA_WIDTH - 1);

    state_t state_q, state_d;

    logic [PHASE_WIDTH-1:0] phase_q;
    logic [15:0]            period_cnt_q;
    logic [PHASE_WIDTH-1:0] fword_sh_q, fword_act_q;
    logic [7:0]             amp_sh_q, amp_act_q, amp_pipe_q;
    logic [15:0]            burst_sh_q, burst_act_q;
    logic                   valid_pipe_q;
    logic [DATA_WIDTH-1:0]  dac_data_q;
    logic                   dac_valid_q;
    logic                   done_q;

    logic [PHASE_WIDTH:0]   phase_sum;
    logic                   wrap;
    logic                   last_wrap;
    logic                   run_start;
    logic                   run_done;

    logic [DATA_WIDTH:0]    centered;
    logic [PROD_WIDTH-1:0]  centered_ext;
    logic [PROD_WIDTH-1:0]  amp_ext;
    logic [PROD_WIDTH-1:0]  product;
    logic [DATA_WIDTH-1:0]  scaled;

    assign phase_sum = {1'b0, phase_q} + {1'b0, fword_act_q};
    assign wrap      = (state_q == ST_RUN) && phase_sum[PHASE_WIDTH];
    assign last_wrap = wrap && (burst_act_q != 16'd0) && ((period_cnt_q + 16'd1) == burst_act_q);

    always_comb begin
        state_d   = state_q;
        run_start = 1'b0;
        run_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d   = ST_RUN;
                    run_start = 1'b1;
                end
            end
            ST_RUN: begin
                // abort wins over a burst completing on the same edge
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (last_wrap) begin
                    state_d  = ST_IDLE;
                    run_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fword_sh_q <= '0;
            amp_sh_q   <= '0;
            burst_sh_q <= '0;
        end else if (bus.cfg_load) begin
            fword_sh_q <= bus.cfg_fword;
            amp_sh_q   <= bus.cfg_amp;
            burst_sh_q <= bus.cfg_burst;
        end
    end

    // Shadow equals active unless reloaded, so copying on every wrap only ever
    // applies a pending reload at a period boundary; burst stays fixed per run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= '0;
            period_cnt_q <= '0;
            fword_act_q  <= '0;
            amp_act_q    <= '0;
            burst_act_q  <= '0;
        end else if (run_start) begin
            phase_q      <= '0;
            period_cnt_q <= '0;
            fword_act_q  <= fword_sh_q;
            amp_act_q    <= amp_sh_q;
            burst_act_q  <= burst_sh_q;
        end else if (state_q == ST_RUN) begin
            phase_q <= (state_d == ST_IDLE) ? '0 : phase_sum[PHASE_WIDTH-1:0];
            if (wrap) begin
                period_cnt_q <= period_cnt_q + 16'd1;
                fword_act_q  <= fword_sh_q;
                amp_act_q    <= amp_sh_q;
            end
        end
    end

    // Low bits of a two's-complement product do not depend on operand signedness,
    // so unsigned operands at full product width give the signed result.
    assign centered     = {1'b0, bus.rom_data} - MIDSCALE;
    assign centered_ext = {{9{centered[DATA_WIDTH]}}, centered};
    assign amp_ext      = {{(DATA_WIDTH + 2){1'b0}}, amp_pipe_q};
    assign product      = centered_ext * amp_ext;
    assign scaled       = {~product[DATA_WIDTH+7], product[DATA_WIDTH+6:8]};

    // amp_pipe_q keeps the gain aligned with the ROM word one cycle behind rom_addr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe_q <= 1'b0;
            amp_pipe_q   <= '0;
            dac_data_q   <= IDLE_CODE;
            dac_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            valid_pipe_q <= (state_q == ST_RUN);
            amp_pipe_q   <= amp_act_q;
            dac_valid_q  <= valid_pipe_q;
            dac_data_q   <= valid_pipe_q ? scaled : IDLE_CODE;
            done_q       <= run_done;
        end
    end

    assign bus.rom_addr  = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
    assign bus.dac_data  = dac_data_q;
    assign bus.dac_valid = dac_valid_q;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_wave_rom_sequencer.sv
// tb/tb_wave_rom_sequencer.sv - self-checking bench for wave_rom_sequencer
module tb_wave_rom_sequencer;
    logic clk = 1'b0;
    logic rst_n;

    wave_rom_sequencer_if bus ();

    wave_rom_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_mem [1024];
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] f;
        logic [7:0]  a;
        logic [15:0] b;
        int          stop_at;
        int          probe_k;
        int          exp_len;
        logic [7:0]  exp_probe;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s idx=%0d actual=%h expected=%h", name, idx, act, exp);
    endtask

    function automatic logic [31:0] pack(input logic b, input logic d, input logic v,
                                         input logic [9:0] ad, input logic [7:0] dd);
        return {11'b0, b, d, v, ad, dd};
    endfunction

    function automatic logic [31:0] outs();
        return pack(bus.busy, bus.done, bus.dac_valid, bus.rom_addr, bus.dac_data);
    endfunction

    function automatic logic [7:0] scale(input logic [7:0] d, input logic [7:0] a);
        int p, s;
        p = (int'(d) - 128) * int'(a);
        s = (p >= 0) ? p / 256 : -((-p + 255) / 256);
        return 8'(s + 128);
    endfunction

    function automatic logic [9:0] addr_at(input logic [31:0] f, input int k);
        longint ph;
        ph = (longint'(f) * longint'(k)) & 64'h0000_0000_FFFF_FFFF;
        return ph[31:22];
    endfunction

    // Closed-form model: run of length L = ceil(burst*2^32/fword), or stop point if earlier.
    task automatic run_check(input logic [31:0] f, input logic [7:0] a, input logic [15:0] b,
                             input int stop_at, input int probe_k,
                             output int busy_len, output logic [7:0] probe_dac);
        longint     lb;
        int         l_eff;
        logic       exp_busy, exp_valid, exp_done;
        logic [9:0] exp_addr;
        logic [7:0] exp_dac;
        if (b != 0 && f != 0) lb = ((longint'(b) << 32) + longint'(f) - 1) / longint'(f);
        else lb = 64'sd1 << 40;
        l_eff = (stop_at > 0 && stop_at <= lb) ? stop_at : int'(lb);
        busy_len  = 0;
        probe_dac = 8'h00;
        @(negedge clk);
        bus.cfg_fword = f; bus.cfg_amp = a; bus.cfg_burst = b; bus.cfg_load = 1'b1;
        @(negedge clk);
        bus.cfg_load = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < l_eff + 4; k++) begin
            exp_busy  = (k < l_eff);
            exp_addr  = exp_busy ? addr_at(f, k) : 10'd0;
            exp_valid = (k >= 2) && (k - 2 < l_eff);
            exp_dac   = 8'h80;
            if (exp_valid) exp_dac = scale(rom_mem[addr_at(f, k - 2)], a);
            exp_done  = (k == l_eff) && (stop_at == 0 || lb < stop_at);
            check("run", k, outs(), pack(exp_busy, exp_done, exp_valid, exp_addr, exp_dac));
            if (bus.busy) busy_len++;
            if (k == probe_k) probe_dac = bus.dac_data;
            if (stop_at > 0 && k == stop_at - 1) bus.stop = 1'b1;
            @(negedge clk);
            bus.stop = 1'b0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          len, nxt, exp_addr, step;
        logic [7:0]  pd, a1, a2, amp_cur;
        logic        loaded, pending;
        logic [15:0] e;
        logic [15:0] pq [$];
        logic [31:0] rf;
        logic [7:0]  ra;
        logic [15:0] rb;
        int          rs;
        longint      rlb;

        vecs[0] = '{32'h0040_0000, 8'd128, 16'd0, 600, 257, 600,  8'hBF};
        vecs[1] = '{32'h0040_0000, 8'd128, 16'd0, 600, 258, 600,  8'h40};
        vecs[2] = '{32'h0040_0000, 8'd128, 16'd2, 0,   2,   2048, 8'h40};
        vecs[3] = '{32'h4000_0000, 8'd200, 16'd3, 0,   3,   12,   8'h1C};
        vecs[4] = '{32'h3000_0000, 8'd64,  16'd1, 0,   3,   6,    8'h90};
        vecs[5] = '{32'hFFFF_FFFF, 8'd255, 16'd1, 0,   2,   2,    8'h00};
        vecs[6] = '{32'h8000_0001, 8'd10,  16'd5, 0,   3,   10,   8'h7B};
        vecs[7] = '{32'h4000_0000, 8'd1,   16'd3, 12,  2,   12,   8'h7F};
        vecs[8] = '{32'h0000_0000, 8'd255, 16'd1, 50,  10,  50,   8'h00};
        vecs[9] = '{32'h0040_0000, 8'd255, 16'd1, 0,   257, 1024, 8'hFE};

        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 8'(i);
        for (int i = 0; i < 5; i++) begin
            bus.cfg_fword = $urandom; bus.cfg_amp = 8'($urandom); bus.cfg_burst = 16'($urandom);
            bus.cfg_load = 1'($urandom); bus.start = 1'($urandom); bus.stop = 1'($urandom);
            @(negedge clk);
            check("reset", i, outs(), pack(1'b0, 1'b0, 1'b0, 10'd0, 8'h80));
        end
        bus.cfg_load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_check(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].stop_at, vecs[i].probe_k, len, pd);
            check("busy_len", i, len, vecs[i].exp_len);
            check("probe_dac", i, pd, vecs[i].exp_probe);
        end

        for (int i = 0; i < 1024; i++) rom_mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            rf = $urandom_range(32'h0FFF_FFFF, 32'h0200_0000);
            ra = 8'($urandom);
            rb = 16'($urandom_range(3, 0));
            rlb = ((longint'(rb) << 32) + longint'(rf) - 1) / longint'(rf);
            if (rb == 0) rs = $urandom_range(300, 20);
            else if ($urandom_range(2, 0) == 0) rs = $urandom_range(int'(rlb) + 1, 1);
            else rs = 0;
            run_check(rf, ra, rb, rs, 0, len, pd);
        end

        // idle: stop together with start must not launch a run
        @(negedge clk);
        bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("start_stop_idle", 0, outs(), pack(1'b0, 1'b0, 1'b0, 10'd0, 8'h80));
        repeat (2) @(negedge clk);
        check("start_stop_idle", 1, outs(), pack(1'b0, 1'b0, 1'b0, 10'd0, 8'h80));

        // mid-run reload: new step and gain take effect at the wrap to address 0
        a1 = 8'($urandom);
        a2 = a1 ^ 8'h5A;
        bus.cfg_fword = 32'h0040_0000; bus.cfg_amp = a1; bus.cfg_burst = 16'd0; bus.cfg_load = 1'b1;
        @(negedge clk);
        bus.cfg_load = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        exp_addr = 0; step = 1; amp_cur = a1; loaded = 1'b0; pending = 1'b0;
        pq.delete();
        for (int k = 0; k < 1400; k++) begin
            check("reload_addr", k, {22'b0, bus.rom_addr}, exp_addr);
            if (k >= 2) begin
                e = pq.pop_front();
                check("reload_dac", k, {24'b0, bus.dac_data}, {24'b0, scale(e[15:8], e[7:0])});
            end
            pq.push_back({rom_mem[exp_addr], amp_cur});
            if (!loaded && exp_addr == 300) begin
                bus.cfg_fword = 32'h0080_0000; bus.cfg_amp = a2; bus.cfg_burst = 16'd1;
                bus.cfg_load = 1'b1; loaded = 1'b1; pending = 1'b1;
            end
            if (k == 100) bus.start = 1'b1;
            nxt = exp_addr + step;
            if (nxt >= 1024) begin
                nxt -= 1024;
                if (pending) begin
                    step = 2; amp_cur = a2; pending = 1'b0;
                end
            end
            exp_addr = nxt;
            @(negedge clk);
            bus.cfg_load = 1'b0; bus.start = 1'b0;
        end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("reload_stop_busy", 0, {31'b0, bus.busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("reload_drain", 0, outs(), pack(1'b0, 1'b0, 1'b0, 10'd0, 8'h80));

        // asynchronous reset mid-run, then a clean restart
        bus.cfg_fword = 32'h0100_0000; bus.cfg_amp = 8'd200; bus.cfg_burst = 16'd0; bus.cfg_load = 1'b1;
        @(negedge clk);
        bus.cfg_load = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_reset_busy", 0, {31'b0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 0, outs(), pack(1'b0, 1'b0, 1'b0, 10'd0, 8'h80));
        @(negedge clk);
        rst_n = 1'b1;
        run_check(32'h0800_0000, 8'd77, 16'd2, 0, 0, len, pd);
        check("restart_len", 0, len, 64);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
